// File: rtl/squeeze_serializer_if.sv
`default_nettype none
// squeeze_serializer_if -- permuted-block input handshake and 64-bit output word stream (rev 1.0)
interface squeeze_serializer_if;
  logic          block_valid;
  logic [1343:0] block_data;
  logic          block_ready;
  logic          dout_valid;
  logic          dout_ready;
  logic [63:0]   dout_data;
  logic [7:0]    dout_keep;
  logic          dout_last;

  modport master (
    input  block_valid, block_data, dout_ready,
    output block_ready, dout_valid, dout_data, dout_keep, dout_last
  );

  modport slave (
    output block_valid, block_data, dout_ready,
    input  block_ready, dout_valid, dout_data, dout_keep, dout_last
  );
endinterface
`default_nettype wire

// File: rtl/squeeze_serializer.sv
`default_nettype none
// squeeze_serializer -- emits rate-sized Keccak state blocks as a 64-bit word stream (rev 1.0)
module squeeze_serializer #(
  parameter int LEN_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic             mode,
  input  wire logic [LEN_W-1:0] out_len,
  output logic                  perm_req,
  output logic                  busy,
  output logic                  done,
  squeeze_serializer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLOCK = 2'd1,
    EMIT       = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1343:0]     hold;
  logic [4:0]        rate;
  logic [4:0]        word_idx;
  logic [LEN_W-1:0]  remaining;

  logic              is_last;
  logic              wrap;
  logic [LEN_W-1:0]  step;

  assign is_last = (remaining <= LEN_W'(8));
  assign wrap    = (word_idx == rate - 5'd1);
  assign step    = is_last ? remaining : LEN_W'(8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    busy            = 1'b1;
    done            = 1'b0;
    bus.block_ready = 1'b0;
    bus.dout_valid  = 1'b0;
    bus.dout_data   = '0;
    bus.dout_keep   = '0;
    bus.dout_last   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (out_len == '0) ? DONE : WAIT_BLOCK;
      end
      WAIT_BLOCK: begin
        bus.block_ready = 1'b1;
        if (bus.block_valid) state_nxt = EMIT;
      end
      EMIT: begin
        bus.dout_valid = 1'b1;
        bus.dout_data  = hold[{word_idx, 6'd0} +: 64];
        bus.dout_keep  = (remaining >= LEN_W'(8)) ? 8'hFF
                                                  : ((8'd1 << remaining[2:0]) - 8'd1);
        bus.dout_last  = is_last;
        if (bus.dout_ready) begin
          if (is_last)   state_nxt = DONE;
          else if (wrap) state_nxt = WAIT_BLOCK;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // perm_req is registered so it lands in the first WAIT_BLOCK cycle of the refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      rate      <= '0;
      word_idx  <= '0;
      remaining <= '0;
      perm_req  <= 1'b0;
    end else begin
      perm_req <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rate      <= mode ? 5'd17 : 5'd21;
            remaining <= out_len;
          end
        end
        WAIT_BLOCK: begin
          if (bus.block_valid) begin
            hold     <= bus.block_data;
            word_idx <= '0;
          end
        end
        EMIT: begin
          if (bus.dout_ready) begin
            remaining <= remaining - step;
            if (!is_last) begin
              if (wrap) perm_req <= 1'b1;
              else      word_idx <= word_idx + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
